// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg: shared types for the FIFO burst reader.
// Holds the FSM state enum and the counter-width helper.
package fifo_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  // Bits needed to count from 0 up to and including n.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry FIFO-order buffer with a valid/ready output.
// Ports: push/push_data in, count out, data/valid out, ready in.
module stream_buf2 #(
  parameter int DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  output logic [1:0]        count,
  output logic [DWIDTH-1:0] data,
  output logic              valid,
  input  logic              ready
);

  logic [DWIDTH-1:0] e0;
  logic [DWIDTH-1:0] e1;
  logic              pop;

  assign pop   = valid && ready;
  assign valid = (count != 2'd0);
  assign data  = e0;

  // e0 is always the head; e1 only holds data at count 2.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= push_data;
          else               e1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops BURST_LEN words from a showahead FIFO
// once a full burst is present and emits them as one framed packet.
// Ports: fifo_* (FIFO side), data/valid/ready/sop/eop stream, busy_o.
module fifo_burst_reader
  import fifo_burst_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 8,
  parameter int BURST_LEN = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic              fifo_full_i,
  input  logic [AWIDTH-1:0] fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              startofpacket_o,
  output logic              endofpacket_o,
  output logic              busy_o
);

  localparam int TW = cnt_w(BURST_LEN);
  localparam logic [TW-1:0] LAST = TW'(BURST_LEN - 1);
  localparam logic [AWIDTH:0] BL_A = (AWIDTH + 1)'(BURST_LEN);

  state_t          state;
  logic [TW-1:0]   rd_cnt;
  logic [TW-1:0]   tx_cnt;
  logic [AWIDTH:0] avail;
  logic [1:0]      buf_cnt;
  logic            hs;

  // usedw wraps to 0 at full, so full stands in for 2**AWIDTH.
  assign avail = fifo_full_i ? {1'b1, {AWIDTH{1'b0}}}
                             : {1'b0, fifo_usedw_i};

  assign fifo_rdreq_o = (state == RUN) && !fifo_empty_i
                        && (buf_cnt != 2'd2);
  assign hs              = valid_o && ready_i;
  assign startofpacket_o = valid_o && (tx_cnt == '0);
  assign endofpacket_o   = valid_o && (tx_cnt == LAST);
  assign busy_o          = (state != IDLE);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state  <= IDLE;
      rd_cnt <= '0;
      tx_cnt <= '0;
    end else begin
      if (hs) tx_cnt <= tx_cnt + TW'(1);
      case (state)
        IDLE: begin
          if (avail >= BL_A) begin
            state  <= RUN;
            rd_cnt <= '0;
            tx_cnt <= '0;
          end
        end
        RUN: begin
          if (fifo_rdreq_o) begin
            rd_cnt <= rd_cnt + TW'(1);
            if (rd_cnt == LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && endofpacket_o) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  stream_buf2 #(
    .DWIDTH(DWIDTH)
  ) u_buf (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .push     (fifo_rdreq_o),
    .push_data(fifo_q_i),
    .count    (buf_cnt),
    .data     (data_o),
    .valid    (valid_o),
    .ready    (ready_i)
  );

endmodule
